// File: rtl/frame_load_sequencer.sv
// Frame loader: unpacks FIFO words into pixels and writes them to the
// back bank of a multi-bank image memory, then flips the front bank.
//
// Ports:
//   clk50, reset     - clock, async active-high reset
//   start            - one-cycle frame load request (IDLE/RUN only)
//   fifo_dout/valid  - first-word-fall-through FIFO head and not-empty
//   fifo_level       - FIFO occupancy, drives SDRAM pause/unpause
//   fifo_pop         - consume head word this cycle (combinational)
//   sdram_pause      - registered pause request
//   sdram_unpause    - registered unpause request
//   mem_we/addr/din  - image memory write port, addr = {bank, pixel}
//   front_bank       - bank currently shown by the display
//   busy             - high while loading or swapping
//   load_done        - one-cycle pulse when a frame completes
//
// Optional build macro FRAME_LOADER_AUTOSTART_EN: leave IDLE for LOAD
// on the first clock after reset without waiting for start.

module frame_load_sequencer #(
  parameter int FIFO_W      = 16,
  parameter int PIXEL_BYTES = 3,
  parameter int N_PIXELS    = 512,
  parameter int N_BANKS     = 2,
  parameter int LEVEL_W     = 10,
  parameter int HW_MARK     = 384,
  parameter int LW_MARK     = 128,
  localparam int PIX_W      = $clog2(N_PIXELS),
  localparam int BANK_W     = $clog2(N_BANKS),
  localparam int ADDR_W     = PIX_W + BANK_W,
  localparam int DIN_W      = PIXEL_BYTES * 8
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               start,
  input  logic [FIFO_W-1:0]  fifo_dout,
  input  logic               fifo_valid,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_pop,
  output logic               sdram_pause,
  output logic               sdram_unpause,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DIN_W-1:0]   mem_din,
  output logic [BANK_W-1:0]  front_bank,
  output logic               busy,
  output logic               load_done
);

  localparam int WORD_BYTES = FIFO_W / 8;
  localparam int ACC_BYTES  = PIXEL_BYTES - 1 + WORD_BYTES;
  localparam int ACC_W      = ACC_BYTES * 8;
  localparam int CNT_W      = $clog2(ACC_BYTES + 1);
  localparam int IDX_W      = PIX_W + 1;

  localparam logic [CNT_W-1:0]   PB_C   = CNT_W'(PIXEL_BYTES);
  localparam logic [CNT_W-1:0]   WB_C   = CNT_W'(WORD_BYTES);
  localparam logic [IDX_W-1:0]   NPIX_C = IDX_W'(N_PIXELS);
  localparam logic [LEVEL_W-1:0] HW_C   = LEVEL_W'(HW_MARK);
  localparam logic [LEVEL_W-1:0] LW_C   = LEVEL_W'(LW_MARK);
  localparam logic [BANK_W-1:0]  ONE_B  = BANK_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWAP,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BANK_W-1:0]  front_q, front_d;
  logic [BANK_W-1:0]  back_q, back_d;
  logic               pause_q, pause_d;
  logic               unpause_q, unpause_d;

  logic               boot;
  logic               in_load;
  logic               emit;
  logic               pop;
  logic               frame_end;
  logic               hi_lvl;
  logic [CNT_W-1:0]   rem;
  logic [IDX_W-1:0]   idx_nxt;
  logic [ACC_W-1:0]   acc_shift;

`ifdef FRAME_LOADER_AUTOSTART_EN
  logic boot_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) boot_q <= 1'b1;
    else       boot_q <= 1'b0;
  end

  assign boot = boot_q;
`else
  assign boot = 1'b0;
`endif

  // Datapath: emit the oldest pixel when enough bytes are buffered,
  // refill only when what remains cannot form the next pixel.
  always_comb begin
    in_load   = (state_q == S_LOAD);
    emit      = in_load && (cnt_q >= PB_C) && (idx_q < NPIX_C);
    rem       = emit ? (cnt_q - PB_C) : cnt_q;
    idx_nxt   = idx_q + IDX_W'(emit);
    pop       = in_load && fifo_valid && (rem < PB_C) &&
                (idx_nxt < NPIX_C);
    frame_end = emit && (idx_nxt == NPIX_C);
    acc_shift = emit ? (acc_q << (PIXEL_BYTES * 8)) : acc_q;
    hi_lvl    = (fifo_level >= HW_C);
  end

  // Next-state and register inputs.
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    back_d    = back_q;
    idx_d     = idx_nxt;
    cnt_d     = pop ? (rem + WB_C) : rem;
    acc_d     = acc_shift;
    pause_d   = !in_load || hi_lvl;
    unpause_d = in_load && (fifo_level <= LW_C) && !hi_lvl;

    // Appended bytes sit directly behind the residual ones, MSB first.
    if (pop) begin
      for (int j = 0; j < ACC_BYTES; j++) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (int'(rem) + k == j) begin
            acc_d[ACC_W-1-8*j -: 8] = fifo_dout[FIFO_W-1-8*k -: 8];
          end
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start || boot) begin
          state_d = S_LOAD;
          back_d  = front_q + ONE_B;
          idx_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_LOAD: begin
        if (frame_end) state_d = S_SWAP;
      end
      S_SWAP: begin
        state_d = S_RUN;
        front_d = back_q;
        cnt_d   = '0;
        acc_d   = '0;
      end
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          back_d  = front_q + ONE_B;
          idx_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      front_q   <= '0;
      back_q    <= '0;
      pause_q   <= 1'b0;
      unpause_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      front_q   <= front_d;
      back_q    <= back_d;
      pause_q   <= pause_d;
      unpause_q <= unpause_d;
    end
  end

  assign fifo_pop      = pop;
  assign sdram_pause   = pause_q;
  assign sdram_unpause = unpause_q;
  assign mem_we        = emit;
  assign mem_addr      = emit ? {back_q, idx_q[PIX_W-1:0]} : '0;
  assign mem_din       = emit ? acc_q[ACC_W-1 -: DIN_W] : '0;
  assign front_bank    = front_q;
  assign busy          = in_load || (state_q == S_SWAP);
  assign load_done     = (state_q == S_SWAP);

endmodule

// File: tb/tb_frame_load_sequencer.sv
// Bench for frame_load_sequencer: small frame (4 pixels x 3 bytes),
// per-cycle model compare plus directed literal expectations.

module tb_frame_load_sequencer;

  localparam int NPIX = 4;

`ifdef FRAME_LOADER_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk50;
  logic        reset;
  logic        start;
  logic [15:0] fifo_dout;
  logic        fifo_valid;
  logic [9:0]  fifo_level;
  logic        fifo_pop;
  logic        sdram_pause;
  logic        sdram_unpause;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [23:0] mem_din;
  logic [0:0]  front_bank;
  logic        busy;
  logic        load_done;

  frame_load_sequencer #(
    .FIFO_W(16), .PIXEL_BYTES(3), .N_PIXELS(NPIX), .N_BANKS(2),
    .LEVEL_W(10), .HW_MARK(384), .LW_MARK(128)
  ) dut (
    .clk50(clk50), .reset(reset), .start(start),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
    .fifo_level(fifo_level), .fifo_pop(fifo_pop),
    .sdram_pause(sdram_pause), .sdram_unpause(sdram_unpause),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .front_bank(front_bank), .busy(busy), .load_done(load_done)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // stimulus state
  logic [15:0] fq [$];
  logic [15:0] wbuf [$];
  logic        rst_v = 1'b1;
  logic        start_v = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  lvl = 10'd200;

  // model state: 0 idle, 1 load, 2 swap, 3 run
  int          m_st = 0;
  logic        m_front = 1'b0;
  logic        m_back = 1'b0;
  logic [2:0]  m_wcnt = '0;
  logic        m_boot = AUTO;
  logic        e_pause = 1'b0;
  logic        e_unp = 1'b0;
  logic [23:0] exp_px [$];
  logic [26:0] wlog [$];
  logic [23:0] px;
  int          pop_cnt = 0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          gap_pop = 0;
  int          gap_we = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk50);
    cyc++;
    reset      = rst_v;
    start      = start_v;
    fifo_level = lvl;
    fifo_valid = (fq.size() != 0) && !stall;
    fifo_dout  = (fq.size() != 0) ? fq[0] : 16'h0;
    #3;
  endtask

  // Byte stream -> expected pixels, MSB byte of each word first.
  task automatic queue_frame();
    logic [7:0] b [$];
    fq.delete();
    exp_px.delete();
    wlog.delete();
    foreach (wbuf[i]) begin
      fq.push_back(wbuf[i]);
      b.push_back(wbuf[i][15:8]);
      b.push_back(wbuf[i][7:0]);
    end
    for (int p = 0; p < NPIX; p++)
      exp_px.push_back({b[3*p], b[3*p+1], b[3*p+2]});
  endtask

  task automatic wait_done(input int d0, input int p0,
                           input bit do_stall);
    int gap;
    gap = 0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      if (do_stall && pop_cnt == p0 + 2 && gap < 10) begin
        stall = 1'b1;
        gap++;
      end else begin
        stall = 1'b0;
      end
      tick();
    end
    stall = 1'b0;
    chk("frame_done", done_cnt - d0, 1);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk50) begin
    #2;
    if (reset) begin
      chk("rst_pop", fifo_pop, 0);
      chk("rst_pause", sdram_pause, 0);
      chk("rst_unpause", sdram_unpause, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_din", mem_din, 0);
      chk("rst_front", front_bank, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", load_done, 0);
      m_st = 0; m_front = 0; m_back = 0; m_wcnt = 0;
      m_boot = AUTO; e_pause = 0; e_unp = 0;
    end else begin
      chk("busy", busy, (m_st == 1) || (m_st == 2));
      chk("load_done", load_done, m_st == 2);
      chk("front_bank", front_bank, m_front);
      chk("pause", sdram_pause, e_pause);
      chk("unpause", sdram_unpause, e_unp);
      chk("pause_excl", sdram_pause && sdram_unpause, 0);
      if (fifo_pop) begin
        chk("pop_legal", (m_st == 1) && fifo_valid, 1);
        pop_cnt++;
        if (stall) gap_pop++;
        if (fq.size() != 0) void'(fq.pop_front());
      end
      if (mem_we) begin
        chk("we_legal", m_st == 1, 1);
        chk("we_expected", exp_px.size() != 0, 1);
        if (exp_px.size() != 0) begin
          px = exp_px.pop_front();
          chk("mem_addr", mem_addr, {m_back, m_wcnt[1:0]});
          chk("mem_din", mem_din, px);
        end
        wlog.push_back({mem_addr, mem_din});
        we_cnt++;
        if (stall) gap_we++;
        m_wcnt++;
      end
      e_pause = (m_st != 1) || (fifo_level >= 10'd384);
      e_unp   = (m_st == 1) && (fifo_level <= 10'd128) &&
                !(fifo_level >= 10'd384);
      case (m_st)
        0, 3: if (start || (m_st == 0 && m_boot)) begin
          m_st = 1; m_back = ~m_front; m_wcnt = 0;
        end
        1: if (m_wcnt == NPIX) m_st = 2;
        2: begin
          m_st = 3; m_front = m_back;
          done_cnt++; done_cyc = cyc;
        end
        default: m_st = 0;
      endcase
      m_boot = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, d0, t0, g0, w0;
    reset = 1'b1; start = 1'b0; fifo_dout = '0;
    fifo_valid = 1'b0; fifo_level = 10'd200;

    repeat (3) tick();
    rst_v = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, AUTO);
    tick();
    chk("idle_busy2", busy, AUTO);

    // Frame 1: basic unpack, extra words must stay in the FIFO.
    wbuf = '{16'h1122, 16'h3344, 16'h5566, 16'h7788,
             16'h99AA, 16'hBBCC, 16'hDDEE, 16'hF001};
    queue_frame();
    p0 = pop_cnt; d0 = done_cnt;
    start_v = 1'b1; tick(); t0 = cyc; start_v = 1'b0;
    wait_done(d0, p0, 1'b0);
    chk("f1_latency", done_cyc - t0, 8);
    chk("f1_pops", pop_cnt - p0, 6);
    chk("f1_nwrites", wlog.size(), 4);
    chk("f1_w0", wlog[0], {3'd4, 24'h112233});
    chk("f1_w1", wlog[1], {3'd5, 24'h445566});
    chk("f1_w2", wlog[2], {3'd6, 24'h778899});
    chk("f1_w3", wlog[3], {3'd7, 24'hAABBCC});
    repeat (3) tick();
    chk("f1_front", front_bank, 1);

    // Frame 2: stall after the 2nd word, loads into bank 0.
    wbuf = '{16'h1122, 16'h3344, 16'h5566, 16'h7788,
             16'h99AA, 16'hBBCC};
    queue_frame();
    p0 = pop_cnt; d0 = done_cnt; g0 = gap_pop; w0 = gap_we;
    start_v = 1'b1; tick(); t0 = cyc; start_v = 1'b0;
    wait_done(d0, p0, 1'b1);
    chk("f2_latency", done_cyc - t0, 18);
    chk("f2_gap_pops", gap_pop - g0, 0);
    chk("f2_gap_we", gap_we - w0, 1);
    chk("f2_w0", wlog[0], {3'd0, 24'h112233});
    chk("f2_w3", wlog[3], {3'd3, 24'hAABBCC});
    tick();
    chk("f2_front", front_bank, 0);

    // Frame 3: watermarks with FIFO held empty, start ignored in LOAD.
    wbuf = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
             16'h090A, 16'h0B0C};
    queue_frame();
    stall = 1'b1;
    d0 = done_cnt;
    start_v = 1'b1; tick(); start_v = 1'b0;
    tick(); tick();
    lvl = 10'd383; tick(); tick();
    chk("wm_383", sdram_pause, 0);
    lvl = 10'd384; tick();
    chk("wm_384_lag", sdram_pause, 0);
    tick();
    chk("wm_384", sdram_pause, 1);
    chk("wm_384_u", sdram_unpause, 0);
    lvl = 10'd129; tick(); tick();
    chk("wm_129_p", sdram_pause, 0);
    chk("wm_129_u", sdram_unpause, 0);
    lvl = 10'd128; tick(); tick();
    chk("wm_128_u", sdram_unpause, 1);
    chk("wm_128_p", sdram_pause, 0);
    lvl = 10'd200;
    stall = 1'b0;
    tick(); tick(); tick();
    start_v = 1'b1; tick(); start_v = 1'b0;
    wait_done(d0, pop_cnt, 1'b0);
    chk("f3_nwrites", wlog.size(), 4);
    chk("f3_w0", wlog[0], {3'd4, 24'h010203});
    chk("f3_w3", wlog[3], {3'd7, 24'h0A0B0C});
    lvl = 10'd128;
    tick(); tick();
    chk("run_pause", sdram_pause, 1);
    chk("run_unpause", sdram_unpause, 0);
    lvl = 10'd200;

    // Frame 4: reset after two words (one leftover byte).
    wbuf = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
             16'h090A, 16'h0B0C};
    queue_frame();
    p0 = pop_cnt;
    start_v = 1'b1; tick(); start_v = 1'b0;
    for (int i = 0; i < 20 && pop_cnt < p0 + 2; i++) tick();
    chk("f4_two_pops", pop_cnt - p0, 2);
    rst_v = 1'b1;
    fq.delete();
    exp_px.delete();
    tick();
    chk("f4_rst_busy", busy, 0);
    tick();
    rst_v = 1'b0;
    tick(); tick();
    chk("f4_post_busy", busy, AUTO);

    // Frame 5: fresh words after reset, no leftover byte.
    wbuf = '{16'hA1A2, 16'hA3A4, 16'hA5A6, 16'hA7A8,
             16'hA9AA, 16'hABAC};
    queue_frame();
    d0 = done_cnt;
    start_v = 1'b1; tick(); start_v = 1'b0;
    wait_done(d0, pop_cnt, 1'b0);
    chk("f5_w0", wlog[0], {3'd4, 24'hA1A2A3});
    chk("f5_w1", wlog[1], {3'd5, 24'hA4A5A6});
    chk("f5_w3", wlog[3], {3'd7, 24'hAAABAC});
    tick();
    chk("f5_front", front_bank, 1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
